online_digit_collector: RTL and testbench

ONLINE_DIGIT_COLLECTOR -- requirements
Module: online_digit_collector

---
 rtl/online_digit_collector_if.sv | 27 ++
 rtl/online_digit_collector.sv | 105 ++++++++++
 tb/tb_online_digit_collector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/online_digit_collector_if.sv
// Handshake/data bundle for online_digit_collector.
//   master: producer/consumer side (drives enable, start, digit_in, word_ready)
//   slave : collector side (drives word_out, word_valid, busy, err)
// Widths follow DIGIT_W / N_DIGITS; they must match the collector's parameters.
interface online_digit_collector_if #(
    parameter int DIGIT_W  = 2,
    parameter int N_DIGITS = 8
);
    logic                          enable;
    logic                          start;
    logic [DIGIT_W-1:0]            digit_in;
    logic                          word_ready;
    logic [N_DIGITS*DIGIT_W-1:0]   word_out;
    logic                          word_valid;
    logic                          busy;
    logic                          err;

    modport master (
        output enable, start, digit_in, word_ready,
        input  word_out, word_valid, busy, err
    );

    modport slave (
        input  enable, start, digit_in, word_ready,
        output word_out, word_valid, busy, err
    );
endinterface

// File: rtl/online_digit_collector.sv
// Collects a serial signed-digit stream (MSD first) from an online arithmetic
// unit into a parallel word. The first DELTA enabled digits after start are
// the unit's online delay and are discarded; the next N_DIGITS enabled
// digits are shifted in. The finished word is held with word_valid until the
// consumer raises word_ready.
// Ports:
//   clk        - rising-edge clock
//   asyn_reset - asynchronous, active-high reset
//   bus        - online_digit_collector_if.slave:
//                enable/start/digit_in/word_ready in,
//                word_out/word_valid/busy/err out
module online_digit_collector #(
    parameter int DIGIT_W  = 2,
    parameter int N_DIGITS = 8,
    parameter int DELTA    = 3
) (
    input  logic                    clk,
    input  logic                    asyn_reset,
    online_digit_collector_if.slave bus
);
    localparam int WORD_W  = N_DIGITS * DIGIT_W;
    localparam int CNT_MAX = (DELTA > N_DIGITS) ? DELTA : N_DIGITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SKIP, COLLECT, DONE} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WORD_W-1:0]   sreg, sreg_n;
    logic                err_q, err_n;
    logic                last_skip, last_col;

    // Terminal tests compare against the digit about to be consumed, so the
    // counter is cleared on the transition instead of ever reaching/wrapping
    // past its terminal value. With DELTA=0 last_skip is never true, and
    // SKIP is never entered anyway.
    assign last_skip = (int'(cnt) == DELTA - 1);
    assign last_col  = (int'(cnt) == N_DIGITS - 1);

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        err_n   = err_q;
        case (state)
            IDLE: begin
                // Start is taken regardless of enable; the old word stays
                // visible until this edge.
                if (bus.start) begin
                    state_n = (DELTA == 0) ? COLLECT : SKIP;
                    cnt_n   = '0;
                    sreg_n  = '0;
                    err_n   = 1'b0;
                end
            end
            SKIP: begin
                if (bus.enable) begin
                    if (last_skip) begin
                        state_n = COLLECT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            COLLECT: begin
                if (bus.enable) begin
                    sreg_n = (sreg << DIGIT_W) | WORD_W'(bus.digit_in);
                    // All bits set is not a legal {plus,minus} code.
                    if (&bus.digit_in) err_n = 1'b1;
                    if (last_col) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // start is deliberately ignored here, even on the handshake edge.
                if (bus.word_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.word_out   = sreg;
    assign bus.word_valid = (state == DONE);
    assign bus.busy       = (state == SKIP) || (state == COLLECT);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_online_digit_collector.sv
module tb_online_digit_collector;
    localparam int DW = 2;
    localparam int ND = 4;
    localparam int DL = 2;
    localparam int WW = DW * ND;

    typedef struct {
        logic [WW-1:0] word;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic asyn_reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [DW-1:0] dq[$];

    online_digit_collector_if #(.DIGIT_W(DW), .N_DIGITS(ND)) b ();
    online_digit_collector_if #(.DIGIT_W(DW), .N_DIGITS(ND)) b0 ();

    online_digit_collector #(.DIGIT_W(DW), .N_DIGITS(ND), .DELTA(DL)) dut (
        .clk(clk), .asyn_reset(asyn_reset), .bus(b.slave));

    online_digit_collector #(.DIGIT_W(DW), .N_DIGITS(ND), .DELTA(0)) dut0 (
        .clk(clk), .asyn_reset(asyn_reset), .bus(b0.slave));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard when a word is presented, then checks
    // that word and err hold for the whole DONE phase.
    initial begin
        exp_t cur;
        logic prev_v = 1'b0;
        cur.word = '0; cur.err = 1'b0; cur.cyc = 0;
        forever begin
            @(negedge clk);
            if (b.word_valid) begin
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(b.word_valid), 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("word", 32'(b.word_out), 32'(cur.word));
                        check("err", 32'(b.err), 32'(cur.err));
                        check("latency", 32'(cyc), 32'(cur.cyc));
                    end
                end else begin
                    check("hold_word", 32'(b.word_out), 32'(cur.word));
                    check("hold_err", 32'(b.err), 32'(cur.err));
                end
                check("busy_in_done", 32'(b.busy), 32'd0);
            end
            prev_v = b.word_valid;
        end
    end

    task automatic set_digs(input logic [1:0] d0, d1, d2, d3, d4, d5);
        dq.delete();
        dq.push_back(d0); dq.push_back(d1); dq.push_back(d2);
        dq.push_back(d3); dq.push_back(d4); dq.push_back(d5);
    endtask

    task automatic rand_digs();
        dq.delete();
        for (int i = 0; i < DL + ND; i++) dq.push_back(2'($urandom_range(3)));
    endtask

    // Reference: of the enabled digits after the start edge, drop the first
    // DL, concatenate the next ND MSD-first; err if any of those is 2'b11.
    // Valid appears on the edge carrying the last of them.
    task automatic run_op(input int en_pct, input int stall_at, input int stall_len,
                          input int ready_delay);
        logic [WW-1:0] w;
        logic          e;
        int            s0;
        int            edges;
        exp_t          x;
        w = '0; e = 1'b0; edges = 0;
        @(negedge clk);
        b.start    = 1'b1;
        b.enable   = 1'($urandom_range(1));
        b.digit_in = 2'($urandom_range(3));
        @(posedge clk);
        @(negedge clk);
        s0 = cyc;
        check("busy_after_start", 32'(b.busy), 32'd1);
        check("cleared_word", 32'(b.word_out), 32'd0);
        check("cleared_err", 32'(b.err), 32'd0);
        for (int i = 0; i < DL + ND; i++) begin
            int idle;
            idle = (i == stall_at) ? stall_len : 0;
            while (idle < 8 && $urandom_range(99) >= en_pct) idle++;
            for (int k = 0; k < idle; k++) begin
                b.enable   = 1'b0;
                b.digit_in = 2'($urandom_range(3));
                b.start    = 1'($urandom_range(1));
                @(posedge clk);
                edges++;
                @(negedge clk);
                check("busy_stall", 32'(b.busy), 32'd1);
            end
            b.enable   = 1'b1;
            b.digit_in = dq[i];
            b.start    = 1'($urandom_range(1));
            if (i >= DL) begin
                w = (w << DW) | WW'(dq[i]);
                if (dq[i] == 2'b11) e = 1'b1;
            end
            if (i == DL + ND - 1) begin
                x.word = w; x.err = e; x.cyc = s0 + edges + 1;
                sb.push_back(x);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (i < DL + ND - 1) check("busy_run", 32'(b.busy), 32'd1);
        end
        check("valid_on_time", 32'(b.word_valid), 32'd1);
        for (int k = 0; k < ready_delay; k++) begin
            b.word_ready = 1'b0;
            b.start      = 1'(k % 2);
            b.enable     = 1'($urandom_range(1));
            @(posedge clk);
            @(negedge clk);
        end
        b.word_ready = 1'b1;
        b.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b.word_ready = 1'b0;
        b.start      = 1'b0;
        check("idle_valid", 32'(b.word_valid), 32'd0);
        check("idle_busy", 32'(b.busy), 32'd0);
        check("idle_retain", 32'(b.word_out), 32'(w));
    endtask

    initial begin
        b.enable = 1'b0; b.start = 1'b0; b.digit_in = '0; b.word_ready = 1'b0;
        b0.enable = 1'b0; b0.start = 1'b0; b0.digit_in = '0; b0.word_ready = 1'b0;
        #1;
        check("rst_word", 32'(b.word_out), 32'd0);
        check("rst_valid", 32'(b.word_valid), 32'd0);
        check("rst_busy", 32'(b.busy), 32'd0);
        check("rst_err", 32'(b.err), 32'd0);
        repeat (2) @(negedge clk);
        asyn_reset = 1'b0;

        // Basic word, full enable: 0x61
        set_digs(2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01);
        run_op(100, -1, 0, 0);
        check("word_61_literal", 32'(b.word_out), 32'h61);
        // Same word with a 3-cycle stall in COLLECT
        run_op(100, 4, 3, 0);
        // Illegal digit: 0x72 with err, held for 3 cycles
        set_digs(2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10);
        run_op(100, -1, 0, 3);
        check("word_72_literal", 32'(b.word_out), 32'h72);
        // Next start clears err; long DONE with start pulsing
        set_digs(2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10);
        run_op(100, -1, 0, 5);

        // Reset between edges after two collected digits
        @(negedge clk);
        b.start = 1'b1; b.enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b.start = 1'b0;
        for (int i = 0; i < DL + 2; i++) begin
            b.digit_in = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(posedge clk);
            @(negedge clk);
        end
        check("partial_word", 32'(b.word_out), 32'h06);
        #2 asyn_reset = 1'b1;
        #1;
        check("arst_word", 32'(b.word_out), 32'd0);
        check("arst_valid", 32'(b.word_valid), 32'd0);
        check("arst_busy", 32'(b.busy), 32'd0);
        check("arst_err", 32'(b.err), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        b.enable = 1'b0;
        set_digs(2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10);
        run_op(100, -1, 0, 1);

        // Randomized operations with random enable gaps
        for (int n = 0; n < 20; n++) begin
            rand_digs();
            run_op(70, -1, 0, int'($urandom_range(3)));
        end

        // DELTA=0 instance: 0xAA after exactly 4 enabled edges
        @(negedge clk);
        b0.start = 1'b1; b0.enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.start = 1'b0;
        check("d0_busy", 32'(b0.busy), 32'd1);
        for (int i = 0; i < ND; i++) begin
            b0.digit_in = 2'b10;
            @(posedge clk);
            @(negedge clk);
            check("d0_valid", 32'(b0.word_valid), (i == ND - 1) ? 32'd1 : 32'd0);
        end
        check("d0_word", 32'(b0.word_out), 32'hAA);
        check("d0_err", 32'(b0.err), 32'd0);
        b0.word_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.word_ready = 1'b0;
        check("d0_idle", 32'(b0.word_valid), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
